serial_to_parallel: RTL and testbench
=====================================

Name: serial_to_parallel

Overview:
Deserializer that sits directly upstream of n_bit_register. It collects N serial bits, one per accepted cycle, into an N-bit word and presents that word on a ready/valid parallel port, which drives the register's data input. Internally it holds two words: a shift buffer and an output holding slot. When the consumer stalls, it applies backpressure to the serial source.

Parameters:
N, 4, word width in bits; legal range N >= 2.
MSB_FIRST, 1, 1 = first received bit lands in bit N-1; 0 = first received bit lands in bit 0.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
serial_in  input  1  serial data bit.
serial_valid  input  1  serial_in is valid this cycle.
serial_ready  output  1  block accepts a bit this cycle.
parallel_out  output  N  assembled word.
parallel_valid  output  1  parallel_out holds an unconsumed word.
parallel_ready  input  1  consumer takes the word this cycle.
busy  output  1  partial word in progress, or shift buffer full.

Behaviour:
- Reset (rst_n low, asynchronous): bit count = 0, shift buffer = 0, full = 0, parallel_out = 0, parallel_valid = 0.
- Reset mid-word discards all partial and pending data.
- Outputs at reset: serial_ready = 1 and busy = 0 while rst_n is low.
- Bit accept: a bit is accepted when serial_valid && serial_ready at a rising edge.
- Cycles with serial_valid = 0 change neither the count nor the buffer.
- Shift, MSB_FIRST = 1: buf <= {buf[N-2:0], serial_in}.
- Shift, MSB_FIRST = 0: buf <= {serial_in, buf[N-1:1]}.
- Count: increments on each accept. Accepting a bit at count N-1 completes the word and wraps the count to 0 in the same edge.
- Slot free (combinational): slot_free = !parallel_valid || parallel_ready.
- Word complete with slot_free = 1: the completed word (including the current bit) loads parallel_out, and parallel_valid = 1 after that edge. Latency is 1 cycle from the last bit's accept edge.
- Word complete with slot_free = 0: the completed word stays in the buffer and full <= 1.
- full = 1 and slot_free = 1: the buffer transfers to parallel_out, parallel_valid stays or becomes 1, and full <= 0.
- serial_ready = !full (registered state only, no combinational path from parallel_ready).
- Consume: parallel_valid && parallel_ready with no new word arriving clears parallel_valid. If a word arrives on the same edge, parallel_out updates and parallel_valid stays 1 (back-to-back).
- While parallel_valid = 1 and the slot is not consumed, parallel_out is stable.
- Throughput: with parallel_ready held at 1, one bit per cycle is sustained and parallel_valid pulses for 1 cycle every N cycles.
- With parallel_ready held at 0: the block accepts 2N bits, then serial_ready drops.
- busy = (count != 0) || full.
- No arithmetic beyond the count. The count width is clog2(N) and it never exceeds N-1.

Test Plan:
1. MSB order, N=4, parallel_ready = 1: serial_valid = 1 with bits 1,0,1,1 on cycles 0-3 -> parallel_out = 4'b1011 and parallel_valid = 1 for exactly cycle 4; busy = 1 during cycles 1-3 and 0 at cycle 4.
2. LSB order, MSB_FIRST = 0, N=4: bits 1,0,0,0 -> parallel_out = 4'b0001.
3. Backpressure: parallel_ready = 0, stream 1,0,1,1 then 0,1,1,0 ->
   - parallel_out = 1011, valid held;
   - serial_ready = 0 after the 8th accept, and further bits are ignored;
   - parallel_ready = 1 for one cycle -> next cycle parallel_out = 0110, valid = 1, serial_ready = 1.
4. Gaps: bits 1,1,0,1 with serial_valid low for 2 cycles between bits 2 and 3 -> word 1101, valid 1 cycle after the 4th accept, count unaffected by the gaps.
5. Reset mid-word: accept 1,1, pulse rst_n low asynchronously (between edges) ->
   - immediately parallel_valid = 0, parallel_out = 0, busy = 0;
   - then bits 0,1,0,1 -> 0101 (no stale bits).
6. Continuous stream of 3 words (1010, 0011, 1111) with ready = 1 -> valid pulses at cycles 4, 8, 12 with the matching words; serial_ready is never low.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer with a shift buffer and an output slot.
// Applies backpressure to the serial source when both words are occupied.
module serial_to_parallel #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         serial_in,
    input  logic         serial_valid,
    output logic         serial_ready,
    output logic [N-1:0] parallel_out,
    output logic         parallel_valid,
    input  logic         parallel_ready,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_buf;
    logic          r_full;
    logic [N-1:0]  r_out;
    logic          r_valid;

    logic          w_accept;
    logic          w_last;
    logic          w_slot_free;
    logic [N-1:0]  w_shift;

    assign w_accept    = serial_valid && !r_full;
    assign w_last      = w_accept && (r_cnt == LAST);
    assign w_slot_free = !r_valid || parallel_ready;

    always_comb begin
        w_shift = r_buf;
        if (MSB_FIRST) begin
            w_shift = {r_buf[N-2:0], serial_in};
        end else begin
            w_shift = {serial_in, r_buf[N-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= w_shift;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // A full buffer implies no accept this cycle, so the branches are disjoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (r_full && w_slot_free) begin
            r_out   <= r_buf;
            r_valid <= 1'b1;
            r_full  <= 1'b0;
        end else if (w_last && w_slot_free) begin
            r_out   <= w_shift;
            r_valid <= 1'b1;
        end else if (w_last) begin
            r_full  <= 1'b1;
        end else if (r_valid && parallel_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign serial_ready   = !r_full;
    assign parallel_out   = r_out;
    assign parallel_valid = r_valid;
    assign busy           = (r_cnt != '0) || r_full;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: MSB and LSB instances against a queue model.
// Directed scenarios pin the model, then a randomized run follows.
module tb_serial_to_parallel;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         parallel_ready = 1'b0;

    logic         m_sready, m_pvalid, m_busy;
    logic [N-1:0] m_pout;
    logic         l_sready, l_pvalid, l_busy;
    logic [N-1:0] l_pout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .serial_in(serial_in), .serial_valid(serial_valid),
        .serial_ready(m_sready),
        .parallel_out(m_pout), .parallel_valid(m_pvalid),
        .parallel_ready(parallel_ready), .busy(m_busy)
    );

    serial_to_parallel #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .serial_in(serial_in), .serial_valid(serial_valid),
        .serial_ready(l_sready),
        .parallel_out(l_pout), .parallel_valid(l_pvalid),
        .parallel_ready(parallel_ready), .busy(l_busy)
    );

    // Model: bits of the partial word, plus completed words awaiting the
    // consumer (at most two: the presented one and one held back).
    logic         part[$];
    logic [N-1:0] pend_m[$];
    logic [N-1:0] pend_l[$];
    logic [N-1:0] last_m, last_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part.delete();
            pend_m.delete();
            pend_l.delete();
            last_m = '0;
            last_l = '0;
        end else begin
            int  depth;
            bit  acc;
            depth = pend_m.size();
            acc   = serial_valid && (depth < 2);
            if (depth > 0 && parallel_ready) begin
                void'(pend_m.pop_front());
                void'(pend_l.pop_front());
            end
            if (acc) begin
                part.push_back(serial_in);
                if (part.size() == N) begin
                    logic [N-1:0] wm, wl;
                    for (int i = 0; i < N; i++) begin
                        wm[N-1-i] = part[i];
                        wl[i]     = part[i];
                    end
                    pend_m.push_back(wm);
                    pend_l.push_back(wl);
                    part.delete();
                end
            end
            if (pend_m.size() > 0) begin
                last_m = pend_m[0];
                last_l = pend_l[0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic ev, eb;
        ev = pend_m.size() > 0;
        eb = (part.size() != 0) || (pend_m.size() == 2);
        chk("m_valid", 32'(m_pvalid), 32'(ev));
        chk("l_valid", 32'(l_pvalid), 32'(ev));
        chk("m_out", 32'(m_pout), 32'(ev ? pend_m[0] : last_m));
        chk("l_out", 32'(l_pout), 32'(ev ? pend_l[0] : last_l));
        chk("m_sready", 32'(m_sready), 32'(pend_m.size() < 2));
        chk("l_sready", 32'(l_sready), 32'(pend_m.size() < 2));
        chk("m_busy", 32'(m_busy), 32'(eb));
        chk("l_busy", 32'(l_busy), 32'(eb));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        serial_valid = 1'b1;
        serial_in    = b;
        tick();
    endtask

    task automatic idle(input int n);
        serial_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [11:0] stream;
    logic [3:0]  w4;

    initial begin
        #2;
        chk("rst_valid", 32'(m_pvalid), 32'd0);
        chk("rst_out", 32'(m_pout), 32'd0);
        chk("rst_sready", 32'(m_sready), 32'd1);
        chk("rst_busy", 32'(m_busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: MSB order, ready high
        parallel_ready = 1'b1;
        bit_in(1'b1);
        chk("t1_busy1", 32'(m_busy), 32'd1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("t1_valid_early", 32'(m_pvalid), 32'd0);
        bit_in(1'b1);
        chk("t1_out", 32'(m_pout), 32'hb);
        chk("t1_valid", 32'(m_pvalid), 32'd1);
        chk("t1_busy4", 32'(m_busy), 32'd0);
        idle(1);
        chk("t1_pulse", 32'(m_pvalid), 32'd0);

        // Test 2: LSB order
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b0);
        bit_in(1'b0);
        chk("t2_lsb_out", 32'(l_pout), 32'h1);
        chk("t2_msb_out", 32'(m_pout), 32'h8);
        idle(1);

        // Test 3: backpressure
        parallel_ready = 1'b0;
        stream = 12'b1011_0110_0000;
        for (int i = 0; i < 8; i++) begin
            w4 = stream[11:8];
            bit_in(stream[11]);
            stream = stream << 1;
            if (i == 3) begin
                chk("t3_first", 32'(m_pout), 32'hb);
                chk("t3_fvalid", 32'(m_pvalid), 32'd1);
            end
        end
        chk("t3_sready", 32'(m_sready), 32'd0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("t3_hold", 32'(m_pout), 32'hb);
        serial_valid   = 1'b0;
        parallel_ready = 1'b1;
        tick();
        parallel_ready = 1'b0;
        chk("t3_second", 32'(m_pout), 32'h6);
        chk("t3_svalid", 32'(m_pvalid), 32'd1);
        chk("t3_sready2", 32'(m_sready), 32'd1);
        chk("t3_busy", 32'(m_busy), 32'd0);
        parallel_ready = 1'b1;
        tick();
        chk("t3_drain", 32'(m_pvalid), 32'd0);

        // Test 4: gaps between bits
        bit_in(1'b1);
        bit_in(1'b1);
        idle(2);
        chk("t4_gap_busy", 32'(m_busy), 32'd1);
        bit_in(1'b0);
        chk("t4_novalid", 32'(m_pvalid), 32'd0);
        bit_in(1'b1);
        chk("t4_out", 32'(m_pout), 32'hd);
        chk("t4_valid", 32'(m_pvalid), 32'd1);
        idle(1);

        // Test 5: asynchronous reset mid-word
        bit_in(1'b1);
        bit_in(1'b1);
        serial_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(m_pvalid), 32'd0);
        chk("t5_out", 32'(m_pout), 32'd0);
        chk("t5_busy", 32'(m_busy), 32'd0);
        chk("t5_sready", 32'(m_sready), 32'd1);
        #1 rst_n = 1'b1;
        tick();
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("t5_out2", 32'(m_pout), 32'h5);
        chk("t5_valid2", 32'(m_pvalid), 32'd1);
        idle(1);

        // Test 6: three back-to-back words
        stream = 12'b1010_0011_1111;
        for (int i = 0; i < 12; i++) begin
            bit_in(stream[11 - i]);
            chk("t6_sready", 32'(m_sready), 32'd1);
            if (i % 4 == 3) begin
                w4 = stream[11 - (i - 3) -: 4];
                chk("t6_valid", 32'(m_pvalid), 32'd1);
                chk("t6_out", 32'(m_pout), 32'(w4));
            end else begin
                chk("t6_gap", 32'(m_pvalid), 32'd0);
            end
        end
        idle(1);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            serial_valid   = ($urandom % 4) != 0;
            serial_in      = $urandom % 2;
            parallel_ready = ($urandom % 3) != 0;
            if (i > 1500 && i < 1800) parallel_ready = 1'b0;
            tick();
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
